// File: rtl/ps2_transceiver_if.sv
// ps2_transceiver_if: the receive and transmit handshake bundle between the PS/2
// host controller and the keyboard/mouse translation logic.
//   rx_valid/rx_data/rx_extended/rx_released : FIFO head, rx_pop consumes it
//   rx_parity_err/rx_frame_err/rx_overflow   : one-cycle receive error pulses
//   tx_data/tx_load                          : command byte and start strobe
//   tx_busy/tx_done/tx_error                 : send status
// Modport slave is the controller side, modport master is the client side.
interface ps2_transceiver_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_extended;
  logic       rx_released;
  logic       rx_pop;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overflow;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport slave (
    input  rx_pop, tx_data, tx_load,
    output rx_valid, rx_data, rx_extended, rx_released,
    output rx_parity_err, rx_frame_err, rx_overflow,
    output tx_busy, tx_done, tx_error
  );

  modport master (
    output rx_pop, tx_data, tx_load,
    input  rx_valid, rx_data, rx_extended, rx_released,
    input  rx_parity_err, rx_frame_err, rx_overflow,
    input  tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_transceiver.sv
// ps2_transceiver: bidirectional PS/2 host controller. Receives device frames into
// a small FIFO (optionally folding E0/F0 keyboard prefixes into flags) and sends
// host-to-device bytes with the inhibit / request-to-send sequence.
//   clk, rst               : system clock, synchronous active-high reset
//   ps2clk_in, ps2dat_in   : raw pad levels (asynchronous)
//   ps2clk_oe, ps2dat_oe   : 1 = pull the pad low, 0 = release
//   bus (slave)            : rx FIFO head / pop, error pulses, tx handshake
module ps2_transceiver #(
  parameter int unsigned CLK_KHZ    = 28000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          KBD_MODE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2clk_in,
  input  logic             ps2dat_in,
  output logic             ps2clk_oe,
  output logic             ps2dat_oe,
  ps2_transceiver_if.slave bus
);

  localparam int unsigned FLT_W   = $clog2(FILTER_LEN + 1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned RX_TO   = CLK_KHZ * 2;
  localparam int unsigned TX_TO   = CLK_KHZ * 15;
  localparam int unsigned INH     = CLK_KHZ / 10;
  localparam int unsigned RX_TO_W = $clog2(RX_TO + 1);
  localparam int unsigned TX_TO_W = $clog2(TX_TO + 1);

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_INHIBIT, TX_RTS, TX_DATA, TX_PARITY, TX_STOP, TX_WAITIDLE
  } tx_state_t;

  // ---------------------------------------------------------------- pad sync
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_s;
  logic       dat_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2clk_in};
      dat_sync <= {dat_sync[0], ps2dat_in};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // Clock deglitch: the filtered level flips only after the synced clock has
  // disagreed with it for FILTER_LEN consecutive cycles.
  logic             clk_filt;
  logic [FLT_W-1:0] flt_cnt;
  logic             fedge;
  logic             redge;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      fedge    <= 1'b0;
      redge    <= 1'b0;
    end else begin
      fedge <= 1'b0;
      redge <= 1'b0;
      if (clk_s == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        flt_cnt  <= '0;
        clk_filt <= clk_s;
        fedge    <= clk_filt;
        redge    <= ~clk_filt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- tx state
  tx_state_t          tx_state, tx_state_n;
  logic [7:0]         tx_shift, tx_shift_n;
  logic               tx_par, tx_par_n;
  logic [3:0]         tx_cnt, tx_cnt_n;
  logic [TX_TO_W-1:0] tx_timer, tx_timer_n;
  logic               clk_oe_q, clk_oe_n;
  logic               dat_oe_q, dat_oe_n;
  logic               tx_busy_q, tx_busy_n;
  logic               tx_done_q, tx_done_n;
  logic               tx_error_q, tx_error_n;
  logic               tx_start;

  assign tx_start = bus.tx_load && (tx_state == TX_IDLE);

  // ---------------------------------------------------------------- rx state
  rx_state_t          rx_state, rx_state_n;
  logic [7:0]         rx_shift, rx_shift_n;
  logic [2:0]         rx_bits, rx_bits_n;
  logic [RX_TO_W-1:0] rx_timer, rx_timer_n;
  logic               rx_strobe_n;
  logic               perr_n, ferr_n;
  logic               perr_q, ferr_q;
  logic               rx_push_q;
  logic [7:0]         rx_byte_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      rx_shift  <= '0;
      rx_bits   <= '0;
      rx_timer  <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_push_q <= 1'b0;
      rx_byte_q <= '0;
    end else begin
      rx_state  <= rx_state_n;
      rx_shift  <= rx_shift_n;
      rx_bits   <= rx_bits_n;
      rx_timer  <= rx_timer_n;
      perr_q    <= perr_n;
      ferr_q    <= ferr_n;
      rx_push_q <= rx_strobe_n;
      if (rx_strobe_n) rx_byte_q <= rx_shift;
    end
  end

  // Receive frame decoder; bits are taken on the filtered falling edge.
  always_comb begin
    rx_state_n  = rx_state;
    rx_shift_n  = rx_shift;
    rx_bits_n   = rx_bits;
    rx_timer_n  = rx_timer + 1'b1;
    rx_strobe_n = 1'b0;
    perr_n      = 1'b0;
    ferr_n      = 1'b0;
    if (fedge) rx_timer_n = '0;

    unique case (rx_state)
      RX_IDLE: begin
        rx_timer_n = '0;
        if (fedge && !dat_s) begin
          rx_state_n = RX_DATA;
          rx_bits_n  = '0;
        end
      end
      RX_DATA: begin
        if (fedge) begin
          rx_shift_n = {dat_s, rx_shift[7:1]};
          rx_bits_n  = rx_bits + 1'b1;
          if (rx_bits == 3'd7) rx_state_n = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fedge) begin
          if (^{rx_shift, dat_s}) begin
            rx_state_n = RX_STOP;
          end else begin
            perr_n     = 1'b1;
            rx_state_n = RX_IDLE;
          end
        end
      end
      RX_STOP: begin
        if (fedge) begin
          rx_state_n = RX_IDLE;
          if (dat_s) rx_strobe_n = 1'b1;
          else       ferr_n      = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase

    // A stalled device abandons the frame without any error report.
    if (rx_state != RX_IDLE && !fedge && rx_timer == RX_TO_W'(RX_TO - 1)) begin
      rx_state_n = RX_IDLE;
    end

    // The host owns the bus while sending: any partial frame is dropped quietly.
    if (tx_start || tx_busy_q) begin
      rx_state_n  = RX_IDLE;
      rx_strobe_n = 1'b0;
      perr_n      = 1'b0;
      ferr_n      = 1'b0;
    end
  end

  // ---------------------------------------------------------------- prefix fold + fifo
  rx_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0] count, count_n;
  logic             pend_ext, pend_rel;
  logic             is_e0, is_f0;
  logic             push, pop, full, wr_en, ovf_n;
  rx_entry_t        push_entry, head_n, head_q;
  logic             rx_valid_q, ovf_q;

  assign is_e0      = KBD_MODE && (rx_byte_q == 8'hE0);
  assign is_f0      = KBD_MODE && (rx_byte_q == 8'hF0);
  assign push       = rx_push_q && !is_e0 && !is_f0;
  assign push_entry = '{ext: pend_ext, rel: pend_rel, data: rx_byte_q};

  // Pointer bookkeeping; the head is precomputed so rx_data is a plain register.
  always_comb begin
    pop      = bus.rx_pop && rx_valid_q;
    full     = (count == CNT_W'(FIFO_DEPTH));
    wr_en    = push && (!full || pop);
    ovf_n    = push && full && !pop;
    rd_ptr_n = pop   ? rd_ptr + 1'b1 : rd_ptr;
    wr_ptr_n = wr_en ? wr_ptr + 1'b1 : wr_ptr;
    count_n  = count + CNT_W'(wr_en) - CNT_W'(pop);
    head_n   = (wr_en && wr_ptr == rd_ptr_n) ? push_entry : mem[rd_ptr_n];
    if (count_n == '0) head_n = '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pend_ext   <= 1'b0;
      pend_rel   <= 1'b0;
      head_q     <= '0;
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      count      <= count_n;
      head_q     <= head_n;
      rx_valid_q <= (count_n != '0);
      ovf_q      <= ovf_n;
      // Prefixes accumulate; any other byte consumes them, dropped or not.
      if (rx_push_q) begin
        if (is_e0) begin
          pend_ext <= 1'b1;
        end else if (is_f0) begin
          pend_rel <= 1'b1;
        end else begin
          pend_ext <= 1'b0;
          pend_rel <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- tx fsm
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      tx_cnt     <= '0;
      tx_timer   <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      tx_state   <= tx_state_n;
      tx_shift   <= tx_shift_n;
      tx_par     <= tx_par_n;
      tx_cnt     <= tx_cnt_n;
      tx_timer   <= tx_timer_n;
      clk_oe_q   <= clk_oe_n;
      dat_oe_q   <= dat_oe_n;
      tx_busy_q  <= tx_busy_n;
      tx_done_q  <= tx_done_n;
      tx_error_q <= tx_error_n;
    end
  end

  // Host-to-device sequencing; the next data level is driven after each device fedge.
  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_cnt_n   = tx_cnt;
    tx_timer_n = tx_timer + 1'b1;
    clk_oe_n   = clk_oe_q;
    dat_oe_n   = dat_oe_q;
    tx_done_n  = 1'b0;
    tx_error_n = 1'b0;

    unique case (tx_state)
      TX_IDLE: begin
        tx_timer_n = '0;
        clk_oe_n   = 1'b0;
        dat_oe_n   = 1'b0;
        if (bus.tx_load) begin
          tx_state_n = TX_INHIBIT;
          tx_shift_n = bus.tx_data;
          tx_par_n   = ~^bus.tx_data;
          clk_oe_n   = 1'b1;
        end
      end
      TX_INHIBIT: begin
        if (tx_timer == TX_TO_W'(INH - 1)) begin
          tx_state_n = TX_RTS;
          tx_timer_n = '0;
          clk_oe_n   = 1'b0;
          dat_oe_n   = 1'b1;
        end
      end
      TX_RTS: begin
        if (fedge) begin
          tx_state_n = TX_DATA;
          dat_oe_n   = ~tx_shift[0];
          tx_shift_n = tx_shift >> 1;
          tx_cnt_n   = 4'd1;
        end
      end
      TX_DATA: begin
        if (fedge) begin
          if (tx_cnt == 4'd8) begin
            tx_state_n = TX_PARITY;
            dat_oe_n   = ~tx_par;
          end else begin
            dat_oe_n   = ~tx_shift[0];
            tx_shift_n = tx_shift >> 1;
            tx_cnt_n   = tx_cnt + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (fedge) begin
          tx_state_n = TX_STOP;
          dat_oe_n   = 1'b0;
        end
      end
      TX_STOP: begin
        // Line released for the stop bit; the device must answer with a low ACK.
        if (fedge) begin
          if (!dat_s) begin
            tx_state_n = TX_WAITIDLE;
          end else begin
            tx_state_n = TX_IDLE;
            tx_error_n = 1'b1;
          end
        end
      end
      TX_WAITIDLE: begin
        if (redge) begin
          tx_state_n = TX_IDLE;
          tx_done_n  = 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase

    if (tx_state != TX_IDLE && tx_state != TX_INHIBIT) begin
      if (fedge) begin
        tx_timer_n = '0;
      end else if (tx_timer == TX_TO_W'(TX_TO - 1)) begin
        tx_state_n = TX_IDLE;
        tx_error_n = 1'b1;
        tx_done_n  = 1'b0;
        clk_oe_n   = 1'b0;
        dat_oe_n   = 1'b0;
      end
    end

    tx_busy_n = (tx_state_n != TX_IDLE);
  end

  // ---------------------------------------------------------------- outputs
  assign ps2clk_oe         = clk_oe_q;
  assign ps2dat_oe         = dat_oe_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_data       = head_q.data;
  assign bus.rx_extended   = head_q.ext;
  assign bus.rx_released   = head_q.rel;
  assign bus.rx_parity_err = perr_q;
  assign bus.rx_frame_err  = ferr_q;
  assign bus.rx_overflow   = ovf_q;
  assign bus.tx_busy       = tx_busy_q;
  assign bus.tx_done       = tx_done_q;
  assign bus.tx_error      = tx_error_q;

endmodule

// File: tb/tb_ps2_transceiver.sv
`timescale 1ns/1ps
// Testbench for ps2_transceiver: a PS/2 device model on wired-AND pads, a receive
// vector table with an expected-entry queue, and hand sequences for overflow,
// stall, send with ACK, send timeout and reset during a send.
module tb_ps2_transceiver;
  localparam int unsigned CLK_KHZ    = 2000;
  localparam int unsigned FILTER_LEN = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned HALF_BIT   = 10;            // 10 us bit cell at 2 MHz
  localparam int unsigned INH_CYC    = CLK_KHZ / 10;  // 100 us
  localparam int unsigned TX_TO_CYC  = CLK_KHZ * 15;  // 15 ms

  typedef struct {
    logic [7:0] data;
    logic       ext;
    logic       rel;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    bit         push;
    logic       ext;
    logic       rel;
    int         perr;
    int         ferr;
  } rx_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic ps2clk_in, ps2dat_in, ps2clk_oe, ps2dat_oe;

  ps2_transceiver_if bus ();

  assign ps2clk_in = dev_clk & ~ps2clk_oe;
  assign ps2dat_in = dev_dat & ~ps2dat_oe;

  ps2_transceiver #(
    .CLK_KHZ(CLK_KHZ), .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH), .KBD_MODE(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .ps2clk_in(ps2clk_in), .ps2dat_in(ps2dat_in),
    .ps2clk_oe(ps2clk_oe), .ps2dat_oe(ps2dat_oe),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0, done_cnt = 0, terr_cnt = 0;
  exp_t       sb[$];
  logic [7:0] tx_sb[$];
  rx_vec_t    vt[13];

  always @(negedge clk) begin
    if (bus.rx_parity_err === 1'b1) perr_cnt++;
    if (bus.rx_frame_err  === 1'b1) ferr_cnt++;
    if (bus.rx_overflow   === 1'b1) ovf_cnt++;
    if (bus.tx_done       === 1'b1) done_cnt++;
    if (bus.tx_error      === 1'b1) terr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dev_bit(input logic b);
    dev_dat = b;
    cycles(HALF_BIT);
    dev_clk = 1'b0;
    cycles(HALF_BIT);
    dev_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~^b;
    if (bad_par) p = ~p;
    dev_bit(1'b0);
    for (int i = 0; i < 8; i++) dev_bit(b[i]);
    dev_bit(p);
    dev_bit(~bad_stop);
    dev_dat = 1'b1;
    cycles(HALF_BIT);
  endtask

  // Pop every FIFO entry and match it against the expected queue in order.
  task automatic drain(input string tag);
    exp_t e;
    int   guard = 0;
    while (bus.rx_valid === 1'b1 && guard < 2 * FIFO_DEPTH) begin
      guard++;
      if (sb.size() == 0) begin
        check({tag, "_extra_entry"}, 32'(bus.rx_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check({tag, "_data"}, 32'(bus.rx_data), 32'(e.data));
        check({tag, "_ext"},  32'(bus.rx_extended), 32'(e.ext));
        check({tag, "_rel"},  32'(bus.rx_released), 32'(e.rel));
      end
      bus.rx_pop = 1'b1;
      @(negedge clk);
      bus.rx_pop = 1'b0;
    end
    check({tag, "_missing_entries"}, 32'(sb.size()), 32'd0);
    check({tag, "_valid_after"}, 32'(bus.rx_valid), 32'd0);
    sb.delete();
  endtask

  // Device side of a host send: clocks 10 bits, reads the wire, then ACKs.
  task automatic tx_with_device(input logic [7:0] d, input logic exp_par);
    int         n;
    int         d0, e0;
    logic [9:0] wire_bits;
    logic [7:0] want;
    d0 = done_cnt;
    e0 = terr_cnt;
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    tx_sb.push_back(d);
    @(negedge clk);
    bus.tx_load = 1'b0;
    bus.tx_data = 8'h00;
    check("tx_busy_rise", 32'(bus.tx_busy), 32'd1);
    n = 0;
    while (ps2clk_oe === 1'b1 && n < 4 * INH_CYC) begin
      n++;
      // A second load during the send must be ignored.
      bus.tx_load = (n == 20);
      @(negedge clk);
    end
    bus.tx_load = 1'b0;
    check("tx_inhibit_cycles", 32'(n), 32'(INH_CYC));
    check("tx_rts_dat_oe", 32'(ps2dat_oe), 32'd1);
    for (int k = 0; k < 10; k++) begin
      cycles(HALF_BIT);
      dev_clk = 1'b0;
      cycles(HALF_BIT);
      wire_bits[k] = ps2dat_in;
      dev_clk = 1'b1;
    end
    cycles(HALF_BIT / 2);
    dev_dat = 1'b0;
    cycles(HALF_BIT / 2);
    dev_clk = 1'b0;
    cycles(HALF_BIT);
    dev_clk = 1'b1;
    cycles(2);
    dev_dat = 1'b1;
    n = 0;
    while (done_cnt == d0 && terr_cnt == e0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    want = tx_sb.pop_front();
    check("tx_wire_data", 32'(wire_bits[7:0]), 32'(want));
    check("tx_wire_parity", 32'(wire_bits[8]), 32'(exp_par));
    check("tx_wire_stop", 32'(wire_bits[9]), 32'd1);
    check("tx_done_pulse", 32'(done_cnt - d0), 32'd1);
    check("tx_no_error", 32'(terr_cnt - e0), 32'd0);
    check("tx_busy_fall", 32'(bus.tx_busy), 32'd0);
    check("tx_lines_released", 32'({ps2clk_oe, ps2dat_oe}), 32'd0);
    cycles(40);
  endtask

  initial begin
    int p0, f0, o0, e0, n;

    bus.rx_pop  = 1'b0;
    bus.tx_load = 1'b0;
    bus.tx_data = 8'h00;

    vt[0]  = '{8'h1C, 0, 0, 1, 1'b0, 1'b0, 0, 0};
    vt[1]  = '{8'hE0, 0, 0, 0, 1'b0, 1'b0, 0, 0};
    vt[2]  = '{8'hF0, 0, 0, 0, 1'b0, 1'b0, 0, 0};
    vt[3]  = '{8'h75, 0, 0, 1, 1'b1, 1'b1, 0, 0};
    vt[4]  = '{8'h75, 0, 0, 1, 1'b0, 1'b0, 0, 0};
    vt[5]  = '{8'h1C, 1, 0, 0, 1'b0, 1'b0, 1, 0};
    vt[6]  = '{8'h1C, 0, 1, 0, 1'b0, 1'b0, 0, 1};
    vt[7]  = '{8'hE0, 0, 0, 0, 1'b0, 1'b0, 0, 0};
    vt[8]  = '{8'h6B, 0, 0, 1, 1'b1, 1'b0, 0, 0};
    vt[9]  = '{8'hF0, 0, 0, 0, 1'b0, 1'b0, 0, 0};
    vt[10] = '{8'h12, 0, 0, 1, 1'b0, 1'b1, 0, 0};
    vt[11] = '{8'h00, 0, 0, 1, 1'b0, 1'b0, 0, 0};
    vt[12] = '{8'hFF, 0, 0, 1, 1'b0, 1'b0, 0, 0};

    cycles(5);
    rst = 1'b0;
    cycles(2);
    check("rst_clk_oe", 32'(ps2clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2dat_oe), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_flags", 32'({bus.rx_extended, bus.rx_released}), 32'd0);
    check("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
    cycles(20);

    // Receive vector table.
    for (int i = 0; i < 13; i++) begin
      p0 = perr_cnt;
      f0 = ferr_cnt;
      o0 = ovf_cnt;
      if (vt[i].push) sb.push_back('{vt[i].b, vt[i].ext, vt[i].rel});
      send_frame(vt[i].b, vt[i].bad_par, vt[i].bad_stop);
      cycles(5);
      check($sformatf("v%0d_parity_err", i), 32'(perr_cnt - p0), 32'(vt[i].perr));
      check($sformatf("v%0d_frame_err", i), 32'(ferr_cnt - f0), 32'(vt[i].ferr));
      check($sformatf("v%0d_overflow", i), 32'(ovf_cnt - o0), 32'd0);
      drain($sformatf("v%0d", i));
    end

    // Overflow: five bytes into a four-entry FIFO, then order check on pop.
    o0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= FIFO_DEPTH) sb.push_back('{8'(i), 1'b0, 1'b0});
      send_frame(8'(i), 0, 0);
    end
    cycles(5);
    check("ovf_pulse", 32'(ovf_cnt - o0), 32'd1);
    check("ovf_valid", 32'(bus.rx_valid), 32'd1);
    drain("ovf");

    // Stall after four data bits, longer than the 2 ms frame timeout.
    p0 = perr_cnt;
    f0 = ferr_cnt;
    dev_bit(1'b0);
    for (int i = 0; i < 4; i++) dev_bit(1'b1);
    dev_dat = 1'b1;
    cycles(3 * CLK_KHZ);
    sb.push_back('{8'h29, 1'b0, 1'b0});
    send_frame(8'h29, 0, 0);
    cycles(5);
    check("stall_no_errors", 32'((perr_cnt - p0) + (ferr_cnt - f0)), 32'd0);
    drain("stall");

    // Host sends with a cooperating device.
    tx_with_device(8'hFF, 1'b1);
    tx_with_device(8'h1C, 1'b0);

    // Reset during the inhibit phase releases the clock line next cycle.
    bus.tx_data = 8'h33;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    cycles(50);
    check("rstsend_clk_oe_before", 32'(ps2clk_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstsend_lines", 32'({ps2clk_oe, ps2dat_oe}), 32'd0);
    check("rstsend_busy", 32'(bus.tx_busy), 32'd0);
    rst = 1'b0;
    cycles(30);

    // No device clock at all: timeout error and both lines released.
    e0 = terr_cnt;
    bus.tx_data = 8'h55;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    n = 1;
    while (terr_cnt == e0 && n < TX_TO_CYC + 2000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_error_pulse", 32'(terr_cnt - e0), 32'd1);
    check("timeout_window", 32'(n >= TX_TO_CYC + INH_CYC - 5 && n <= TX_TO_CYC + INH_CYC + 20), 32'd1);
    check("timeout_lines", 32'({ps2clk_oe, ps2dat_oe}), 32'd0);
    check("timeout_busy", 32'(bus.tx_busy), 32'd0);
    check("timeout_no_done", 32'(bus.tx_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_transceiver.md
# ps2_transceiver

Parametrised bidirectional PS/2 host controller: receives device frames (keyboard or mouse) into a small FIFO, and sends host-to-device command bytes with the proper inhibit/request-to-send sequence. It is the successor of the fixed-rate receive-only port and the separate host-to-keyboard sender. Everything is merged behind one clock, with tunable timing, error reporting and buffering. It sits between the PS/2 pads (open-drain, split into in/oe) and the keyboard/mouse translation logic.

## Interface
- CLK_KHZ, 28000, system clock frequency in kHz; all protocol timings derive from it
- FILTER_LEN, 8, PS/2 clock deglitch length in cycles (2..16)
- FIFO_DEPTH, 4, RX FIFO entries (power of two, 2..16)
- KBD_MODE, 1, 1 = decode E0/F0 prefixes into flags; 0 = raw bytes (mouse)

- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset
- ps2clk_in, ps2dat_in  in  1 each  raw pad levels (asynchronous)
- ps2clk_oe, ps2dat_oe  out  1 each  1 = drive pad low, 0 = release
- rx_valid  out  1  FIFO non-empty
- rx_data  out  8  FIFO head byte
- rx_extended, rx_released  out  1 each  FIFO head flags (0 when KBD_MODE=0)
- rx_pop  in  1  consume head when rx_valid
- rx_parity_err, rx_frame_err, rx_overflow  out  1 each  one-cycle error pulses
- tx_data  in  8  byte to send
- tx_load  in  1  start a send; sampled only when tx_busy=0
- tx_busy  out  1  send in progress
- tx_done  out  1  one-cycle pulse when the ACK bit is received
- tx_error  out  1  one-cycle pulse on timeout or missing ACK

## Operation
- Synchronise both pads through two flops. A falling edge (fedge) is a one-cycle pulse after the sync clock has been high for FILTER_LEN cycles and then low for FILTER_LEN cycles. Rising edge (redge) is defined symmetrically.
- RX FSM: IDLE -> DATA (start bit=0 at fedge) -> PARITY -> STOP -> IDLE. Data is sampled LSB first on fedge, 8 bits.
  - Odd parity fail: rx_parity_err, frame discarded.
  - Stop bit 0: rx_frame_err, frame discarded.
  - No fedge for CLK_KHZ*2 cycles (2 ms) mid-frame: back to IDLE silently.
- KBD_MODE=1:
  - E0 sets a pending-extended flag and F0 sets a pending-released flag; neither is pushed.
  - The next byte is pushed with both flags, then the pending flags clear.
  - KBD_MODE=0: every byte is pushed, flags 0.
- FIFO full on push: byte dropped, rx_overflow pulses, pending flags still clear. Push and pop in the same cycle while full are both honoured.
- TX FSM:
  - INHIBIT: clk_oe=1 for CLK_KHZ/10 cycles (100 µs).
  - RTS: dat_oe=1, clk released; wait for fedge.
  - DATA: 8 bits LSB first; dat_oe=~bit, updated after each fedge.
  - PARITY: odd parity of tx_data.
  - STOP: release data.
  - ACK: at the fedge, the sampled data must be 0, else tx_error.
  - WAITIDLE: redge -> tx_done -> IDLE.
- A tx_load accepted while RX is mid-frame aborts that frame (no error pulse). RX is held in IDLE while tx_busy=1. Pending prefix flags are kept.
- TX timeout: no fedge for CLK_KHZ*15 cycles (15 ms) in any post-INHIBIT state -> tx_error, release both lines, IDLE.

## Timing
- Reset values:
  - ps2clk_oe=ps2dat_oe=0, rx_valid=0, rx_data=0, flags=0, all pulses=0, tx_busy=0.
  - FIFO empty, pending flags cleared, both FSMs IDLE.
- Reset mid-send releases both lines on the next cycle.
- Pad-to-fedge latency: 2 sync cycles + FILTER_LEN.
- RX push occurs 1 cycle after the stop-bit fedge. rx_valid rises on the following cycle, and rx_data is registered at the FIFO head.
- rx_pop with rx_valid: the head advances next cycle. rx_pop when empty is ignored.
- tx_busy rises the cycle after tx_load and falls in the same cycle as tx_done/tx_error.
- tx_load while busy is ignored.

## Test plan
- Keyboard frame 0x1C (parity 0, stop 1), 10 µs bit cell -> rx_valid, rx_data=0x1C, both flags 0, no error pulses.
- Sequence E0 F0 75, KBD_MODE=1 -> exactly one entry: rx_data=0x75, rx_extended=1, rx_released=1. Next byte 0x75 has flags 0.
- Parity bit corrupted on 0x1C -> rx_parity_err pulse, FIFO unchanged.
- Stall after 4 bits for 3 ms, then a good 0x29 -> no entry for the partial frame, 0x29 received cleanly.
- FIFO_DEPTH=4: send 5 bytes with no pop -> 4 entries; 5th drops with an rx_overflow pulse. Pop all -> order preserved.
- tx_load with 0xFF, device model clocks and ACKs:
  - clk_oe low for CLK_KHZ/10 cycles; wire bits 11111111, parity 1.
  - tx_done pulse, tx_busy drops.
- Repeat with no device clock -> tx_error after 15 ms, both oe=0.
